hazard_control_unit: RTL and testbench

- Stall/flush generator for the 5-stage pipeline. It is the control-side complement of the EX-stage bypass logic and covers the hazards forwarding cannot resolve.
- Detects load-use hazards in Decode and squashes wrong-path instructions on a taken branch.
- Sequences a multi-cycle EX operation (MUL/DIV) by holding F/D/E frozen for a fixed latency while bubbling M.

---
 rtl/hazard_pkg.sv | 20 ++
 rtl/hazard_perf_counters.sv | 41 ++++
 rtl/hazard_control_unit.sv | 132 +++++++++++++
 tb/tb_hazard_control_unit.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the hazard control unit
// Contents: FSM state enum, architectural zero register index,
//           statistics counter width, saturating increment helper.
package hazard_pkg;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MC_BUSY = 1'b1
  } hazard_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int STAT_W = 32;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] val);
    return (&val) ? val : val + 1'b1;
  endfunction

endpackage

// File: rtl/hazard_perf_counters.sv
// rtl/hazard_perf_counters.sv - saturating hazard event counters
// Ports:
//   clk, rst           clock, synchronous active-high reset (clears counters)
//   lw_stall_i         load-use stall seen in IDLE this cycle
//   mc_stall_i         StallE asserted this cycle
//   flush_i            FlushD asserted this cycle
//   lw_stall_cnt_o     load-use stall cycle count
//   mc_stall_cnt_o     multi-cycle stall cycle count
//   flush_cnt_o        decode flush cycle count
module hazard_perf_counters
  import hazard_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              lw_stall_i,
  input  logic              mc_stall_i,
  input  logic              flush_i,
  output logic [STAT_W-1:0] lw_stall_cnt_o,
  output logic [STAT_W-1:0] mc_stall_cnt_o,
  output logic [STAT_W-1:0] flush_cnt_o
);

  logic [STAT_W-1:0] lw_cnt_q, mc_cnt_q, fl_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      lw_cnt_q <= '0;
      mc_cnt_q <= '0;
      fl_cnt_q <= '0;
    end else begin
      if (lw_stall_i) lw_cnt_q <= sat_inc(lw_cnt_q);
      if (mc_stall_i) mc_cnt_q <= sat_inc(mc_cnt_q);
      if (flush_i)    fl_cnt_q <= sat_inc(fl_cnt_q);
    end
  end

  assign lw_stall_cnt_o = lw_cnt_q;
  assign mc_stall_cnt_o = mc_cnt_q;
  assign flush_cnt_o    = fl_cnt_q;

endmodule

// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - pipeline stall/flush generator with multi-cycle EX sequencing
// Optional feature macro: HAZARD_STATS_EN (adds LwStallCnt/McStallCnt/FlushCnt outputs)
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   RS1D, RS2D               source registers of the Decode instruction
//   RDE, RegWriteE           destination / write enable of the Execute instruction
//   ResultSrcE0              Execute instruction is a load
//   PCSrcE                   taken branch/jump resolved in Execute
//   MCStartE                 first EX cycle of a multi-cycle op
//   StallF/StallD/StallE     hold PC, IF/ID, ID/EX
//   FlushD/FlushE/FlushM     clear IF/ID, ID/EX, bubble EX/MEM
//   MCBusy                   multi-cycle unit enable
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int MC_LATENCY = 4,
  parameter int CNT_W      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] RS1D,
  input  logic [4:0] RS2D,
  input  logic [4:0] RDE,
  input  logic       RegWriteE,
  input  logic       ResultSrcE0,
  input  logic       PCSrcE,
  input  logic       MCStartE,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushM,
  output logic       MCBusy
`ifdef HAZARD_STATS_EN
  ,
  output logic [STAT_W-1:0] LwStallCnt,
  output logic [STAT_W-1:0] McStallCnt,
  output logic [STAT_W-1:0] FlushCnt
`endif
);

  // The start cycle is itself one stall cycle, so MC_BUSY lasts MC_LATENCY-2
  // cycles. With MC_LATENCY=2 the start cycle alone covers the whole stall.
  localparam logic [CNT_W-1:0] MC_LOAD     = CNT_W'(MC_LATENCY - 2);
  localparam bit               MC_HAS_BUSY = (MC_LATENCY > 2);

  hazard_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lw_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    lw_stall = ResultSrcE0 & RegWriteE & (RDE != REG_ZERO) &
               ((RDE == RS1D) | (RDE == RS2D));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    StallF  = 1'b0;
    StallD  = 1'b0;
    StallE  = 1'b0;
    FlushD  = 1'b0;
    FlushE  = 1'b0;
    FlushM  = 1'b0;
    MCBusy  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (PCSrcE) begin
          // A taken branch overrides a coincident MCStartE: the op is on the wrong path.
          StallF = lw_stall;
          StallD = lw_stall;
          FlushD = 1'b1;
          FlushE = 1'b1;
        end else if (MCStartE) begin
          StallF = 1'b1;
          StallD = 1'b1;
          StallE = 1'b1;
          FlushM = 1'b1;
          MCBusy = 1'b1;
          cnt_d  = MC_LOAD;
          if (MC_HAS_BUSY) state_d = ST_MC_BUSY;
        end else begin
          StallF = lw_stall;
          StallD = lw_stall;
          FlushE = lw_stall;
        end
      end

      ST_MC_BUSY: begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        FlushM = 1'b1;
        MCBusy = 1'b1;
        cnt_d  = cnt_q - 1'b1;
        // Leave once the count reaches zero; <=1 also recovers a stray zero.
        if (cnt_q <= CNT_W'(1)) state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef HAZARD_STATS_EN
  hazard_perf_counters u_perf (
    .clk            (clk),
    .rst            (rst),
    .lw_stall_i     (lw_stall & (state_q == ST_IDLE)),
    .mc_stall_i     (StallE),
    .flush_i        (FlushD),
    .lw_stall_cnt_o (LwStallCnt),
    .mc_stall_cnt_o (McStallCnt),
    .flush_cnt_o    (FlushCnt)
  );
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// tb/tb_hazard_control_unit.sv - randomized self-checking bench for hazard_control_unit
module tb_hazard_control_unit;
  import hazard_pkg::*;

  localparam int MC_LAT = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] RS1D, RS2D, RDE;
  logic       RegWriteE, ResultSrcE0, PCSrcE, MCStartE;
  logic       StallF, StallD, StallE, FlushD, FlushE, FlushM, MCBusy;
`ifdef HAZARD_STATS_EN
  logic [STAT_W-1:0] LwStallCnt, McStallCnt, FlushCnt;
`endif

  always #5 clk = ~clk;

  hazard_control_unit #(.MC_LATENCY(MC_LAT), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .RS1D(RS1D), .RS2D(RS2D), .RDE(RDE),
    .RegWriteE(RegWriteE), .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE),
    .MCStartE(MCStartE), .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .MCBusy(MCBusy)
`ifdef HAZARD_STATS_EN
    , .LwStallCnt(LwStallCnt), .McStallCnt(McStallCnt), .FlushCnt(FlushCnt)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h expected=%h", tag, got, exp);
  endtask

  // Reference model: number of stall cycles still owed to a running op,
  // plus plain event tallies.
  int busy_left;
  int m_lw, m_mc, m_fl;
  logic [6:0] last_obs;   // {StallF,StallD,StallE,FlushD,FlushE,FlushM,MCBusy}

  function automatic logic [6:0] model_out(output logic lw_idle);
    logic lw;
    logic sf, sd, se, fd, fe, fm, mb;
    lw = ResultSrcE0 && RegWriteE && RDE != 0 && (RDE == RS1D || RDE == RS2D);
    lw_idle = 1'b0;
    {sf, sd, se, fd, fe, fm, mb} = '0;
    if (busy_left > 0) begin
      {sf, sd, se, fm, mb} = 5'b11111;
    end else begin
      lw_idle = lw;
      if (PCSrcE) begin
        sf = lw; sd = lw; fd = 1; fe = 1;
      end else if (MCStartE) begin
        {sf, sd, se, fm, mb} = 5'b11111;
      end else begin
        sf = lw; sd = lw; fe = lw;
      end
    end
    return {sf, sd, se, fd, fe, fm, mb};
  endfunction

  task automatic step(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] rde, input logic rw, input logic ld,
                      input logic pc, input logic mc);
    logic [6:0] exp;
    logic lw_idle;
    @(negedge clk);
    rst = r; RS1D = rs1; RS2D = rs2; RDE = rde;
    RegWriteE = rw; ResultSrcE0 = ld; PCSrcE = pc; MCStartE = mc;
    #1;
    exp = model_out(lw_idle);
    last_obs = {StallF, StallD, StallE, FlushD, FlushE, FlushM, MCBusy};
    check("outputs", {25'd0, last_obs}, {25'd0, exp});
`ifdef HAZARD_STATS_EN
    check("lw_cnt", LwStallCnt, m_lw);
    check("mc_cnt", McStallCnt, m_mc);
    check("fl_cnt", FlushCnt, m_fl);
`endif
    @(posedge clk);
    if (r) begin
      busy_left = 0; m_lw = 0; m_mc = 0; m_fl = 0;
    end else begin
      if (lw_idle) m_lw++;
      if (exp[4])  m_mc++;
      if (exp[3])  m_fl++;
      if (busy_left > 0) busy_left--;
      else if (MCStartE && !PCSrcE) busy_left = MC_LAT - 2;
    end
  endtask

  task automatic idle_step();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  int se_count;

  initial begin
    rst = 1; RS1D = 0; RS2D = 0; RDE = 0;
    RegWriteE = 0; ResultSrcE0 = 0; PCSrcE = 0; MCStartE = 0;
    busy_left = 0; m_lw = 0; m_mc = 0; m_fl = 0;
    repeat (2) @(posedge clk);

    idle_step();
    check("reset_outputs", {25'd0, last_obs}, 32'd0);

    step(0, 5, 0, 5, 1, 1, 0, 0);
    check("lu_rs1", {25'd0, last_obs}, 32'b1100100);
    step(0, 0, 5, 5, 1, 1, 0, 0);
    check("lu_rs2", {25'd0, last_obs}, 32'b1100100);
    step(0, 6, 7, 5, 1, 1, 0, 0);
    check("lu_nomatch", {25'd0, last_obs}, 32'd0);
    step(0, 0, 0, 0, 1, 1, 0, 0);
    check("lu_x0", {25'd0, last_obs}, 32'd0);
    step(0, 5, 0, 5, 0, 1, 0, 0);
    check("lu_norw", {25'd0, last_obs}, 32'd0);
    step(0, 1, 2, 3, 0, 0, 1, 0);
    check("branch", {25'd0, last_obs}, 32'b0001100);
    step(0, 5, 2, 5, 1, 1, 1, 0);
    check("branch_lu", {25'd0, last_obs}, 32'b1101100);
    step(0, 0, 0, 0, 0, 0, 1, 1);
    check("branch_mc", {25'd0, last_obs}, 32'b0001100);
    idle_step();
    check("branch_mc_after", {25'd0, last_obs}, 32'd0);

    // Two back-to-back multi-cycle ops.
    for (int k = 0; k < 2; k++) begin
      se_count = 0;
      step(0, 0, 0, 0, 0, 0, 0, 1);
      check("mc_start", {25'd0, last_obs}, 32'b1110011);
      se_count += int'(last_obs[4]);
      for (int i = 0; i < MC_LAT - 2; i++) begin
        step(0, 5, 5, 5, 1, 1, 1, 1);   // lw/branch ignored while busy
        check("mc_busy", {25'd0, last_obs}, 32'b1110011);
        se_count += int'(last_obs[4]);
      end
      check("mc_window", se_count, MC_LAT - 1);
    end
    idle_step();
    check("mc_done", {25'd0, last_obs}, 32'd0);

    // Reset in the second busy cycle.
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    check("rst_midop_busy", {25'd0, last_obs}, 32'b1110011);
    idle_step();
    check("rst_midop_after", {25'd0, last_obs}, 32'd0);
    se_count = 0;
    step(0, 0, 0, 0, 0, 0, 0, 1);
    se_count += int'(last_obs[4]);
    for (int i = 0; i < 4; i++) begin
      idle_step();
      se_count += int'(last_obs[4]);
    end
    check("mc_window_after_rst", se_count, MC_LAT - 1);

`ifdef HAZARD_STATS_EN
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 5, 0, 5, 1, 1, 0, 0);
    step(0, 0, 6, 6, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    repeat (4) idle_step();
    step(0, 0, 0, 0, 0, 0, 1, 0);
    idle_step();
    check("stats_lw", LwStallCnt, 32'd2);
    check("stats_mc", McStallCnt, 32'd3);
    check("stats_fl", FlushCnt, 32'd1);
`endif

    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(99) < 2,
           5'($urandom_range(3)), 5'($urandom_range(3)), 5'($urandom_range(3)),
           $urandom_range(99) < 70, $urandom_range(99) < 40,
           $urandom_range(99) < 15, $urandom_range(99) < 12);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
